// File: rtl/sramlike_pkg.sv
//------------------------------------------------------------------------------
// sramlike_pkg : size encodings, byte-lane mask and misalignment helpers
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sramlike_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE     = 2'd0,
      SIZE_HALF     = 2'd1,
      SIZE_WORD     = 2'd2,
      SIZE_WORD_ALT = 2'd3
   } size_e;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a_lo);
      case (size_e'(size))
         SIZE_BYTE: lane_mask = 4'b0001 << a_lo;
         SIZE_HALF: lane_mask = a_lo[1] ? 4'b1100 : 4'b0011;
         default:   lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
      case (size_e'(size))
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = a_lo[0];
         default:   misaligned = (a_lo != 2'b00);
      endcase
   endfunction

   // Misaligned accesses still complete but never modify memory.
   function automatic logic [3:0] write_enable(input logic [1:0] size, input logic [1:0] a_lo);
      write_enable = misaligned(size, a_lo) ? 4'b0000 : lane_mask(size, a_lo);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bytewrite_ram.sv
//------------------------------------------------------------------------------
// bytewrite_ram : 2^AW x 32-bit storage, per-byte synchronous write,
//                 combinational read of the same address
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bytewrite_ram #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] mem [0:(1<<AW)-1];

      always_ff @(posedge clk) begin
         if (be[g]) begin
            mem[addr] <= wdata[8*g +: 8];
         end
      end

      assign rdata[8*g +: 8] = mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/sramlike_responder.sv
//------------------------------------------------------------------------------
// sramlike_responder : in-order SRAM-like slave with fixed latency and a
//                      bounded outstanding-request queue
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sramlike_responder
   import sramlike_pkg::*;
#(
   parameter int MEM_AW  = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int         CW      = $clog2(QDEPTH + 1);
   localparam int         EAW     = MEM_AW + 2;
   localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);

   logic [CW-1:0]  count;
   logic [2:0]     cd_q    [QDEPTH];
   logic           wr_q    [QDEPTH];
   logic [1:0]     size_q  [QDEPTH];
   logic [EAW-1:0] addr_q  [QDEPTH];
   logic [31:0]    wdata_q [QDEPTH];

   logic           accept;
   logic           retire;
   logic [CW-1:0]  slot;
   logic [3:0]     ram_be;
   logic [31:0]    ram_rdata;
   logic           unused_addr_hi;

   assign unused_addr_hi = ^addr[31:EAW];

   // Derived from the count register only, so a freed slot shows up one cycle late.
   assign addr_ok = (count < CW'(QDEPTH));
   assign accept  = req && addr_ok;
   assign retire  = (count != '0) && (cd_q[0] == 3'd0);
   assign slot    = count - CW'(retire);
   assign ram_be  = (retire && wr_q[0]) ? write_enable(size_q[0], addr_q[0][1:0]) : 4'b0000;

   function automatic logic [2:0] sat_dec(input logic [2:0] v);
      return (v == 3'd0) ? 3'd0 : v - 3'd1;
   endfunction

   bytewrite_ram #(
      .AW (MEM_AW)
   ) u_ram (
      .clk   (clk),
      .be    (ram_be),
      .addr  (addr_q[0][EAW-1:2]),
      .wdata (wdata_q[0]),
      .rdata (ram_rdata)
   );

   // Shift-down queue: entry 0 is always the head; a new entry lands just
   // behind the last valid entry after any retirement this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         data_ok <= 1'b0;
         rdata   <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            cd_q[i]    <= 3'd0;
            wr_q[i]    <= 1'b0;
            size_q[i]  <= 2'd0;
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
         end
      end else begin
         data_ok <= retire;
         rdata   <= (retire && !wr_q[0]) ? ram_rdata : 32'd0;
         count   <= count + CW'(accept) - CW'(retire);
         for (int i = 0; i < QDEPTH; i++) begin
            if (accept && (CW'(i) == slot)) begin
               cd_q[i]    <= CD_INIT;
               wr_q[i]    <= wr;
               size_q[i]  <= size;
               addr_q[i]  <= addr[EAW-1:0];
               wdata_q[i] <= wdata;
            end else if (retire) begin
               cd_q[i]    <= sat_dec(cd_q[(i < QDEPTH-1) ? i+1 : i]);
               wr_q[i]    <= wr_q[(i < QDEPTH-1) ? i+1 : i];
               size_q[i]  <= size_q[(i < QDEPTH-1) ? i+1 : i];
               addr_q[i]  <= addr_q[(i < QDEPTH-1) ? i+1 : i];
               wdata_q[i] <= wdata_q[(i < QDEPTH-1) ? i+1 : i];
            end else begin
               cd_q[i] <= sat_dec(cd_q[i]);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/sramlike_responder.md
SRAMLIKE_RESPONDER -- requirements
Module: sramlike_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address bits (memory = 2^MEM_AW x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from acceptance to data_ok (legal range 1..7).
REQ-003 SHALL have parameter QDEPTH, default 2, meaning maximum outstanding accepted requests (legal 1..4).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-009 SHALL have port addr, input, 32 bits: byte address.
REQ-010 SHALL have port wdata, input, 32 bits: write data, lane-aligned by the initiator.
REQ-011 SHALL have port addr_ok, output, 1 bit: request accepted this cycle when req=1.
REQ-012 SHALL have port data_ok, output, 1 bit: one-cycle completion pulse, in acceptance order.
REQ-013 SHALL have port rdata, output, 32 bits: full read word, valid only with data_ok on a read.

Function
REQ-014 SHALL drive addr_ok = (outstanding count < QDEPTH), from registered state only, with no combinational path from req.
REQ-015 SHALL accept a request on any edge where req=1 and addr_ok=1, capturing wr, size, addr and wdata into an in-order queue entry.
REQ-016 SHALL load each entry's countdown with LATENCY-1 on acceptance and decrement it every cycle, saturating at 0.
REQ-017 SHALL assert data_ok in the cycle after the head entry's countdown reaches 0, so a request accepted at edge N completes at edge N+LATENCY when the queue was empty.
REQ-018 SHALL retire at most one entry per cycle; an entry that is ready but not at the head waits, with each later completion following at least one cycle after the previous one.
REQ-019 SHALL perform both the memory read and the memory write at head retirement, so results reflect strict program order (read-after-write and write-after-read).
REQ-020 SHALL compute byte lanes as: size 0 -> lane addr[1:0]; size 1 -> 4'b0011 when addr[1]=0, else 4'b1100; size 2 or 3 -> 4'b1111.
REQ-021 SHALL treat misaligned accesses (size 1 with addr[0]=1, or size 2/3 with addr[1:0]!=0) as follows: complete them with data_ok, apply no write (lanes 4'b0000), and return the word-aligned read word.
REQ-022 SHALL index memory by addr[MEM_AW+1:2]; higher address bits are ignored, so addresses wrap.
REQ-023 SHALL return the whole addressed word on rdata for reads; lane extraction is the initiator's job. rdata SHALL be 0 on write completions.
REQ-024 SHALL allow acceptance and retirement in the same cycle; the count is unchanged and the new entry is appended behind the remaining entries.
REQ-025 SHALL NOT raise addr_ok in the same cycle that a retirement frees a full queue; it rises one cycle later.
REQ-026 SHALL ignore wr, size, addr and wdata when req=0 or addr_ok=0.

Reset
REQ-027 SHALL, while rst=1 at an edge, empty the queue, clear all countdowns, and drive data_ok=0, rdata=0, and addr_ok=1 from the first cycle after reset.
REQ-028 SHALL, on reset during outstanding requests, drop those requests with no data_ok and no memory write.
REQ-029 SHALL NOT reset memory contents.

Structure
REQ-030 SHALL take the size encodings, the lane-mask function and the misalignment predicate from the shared package sramlike_pkg, which is also used by the memory-control logic.
REQ-031 SHALL instantiate the storage as one sub-module, bytewrite_ram: 2^MEM_AW x 32 bits, 4-bit byte write enable, with a synchronous write and a read available to the retirement logic.

Verification
REQ-032 SHALL cover: after reset, write word 0xDEADBEEF at 0x10, then read 0x10 -> write data_ok at +2, read data_ok with rdata=0xDEADBEEF.
REQ-033 SHALL cover: word 0x11223344 at 0x20, then byte write 0xAA000000 at 0x23, then read 0x20 -> rdata=0xAA223344.
REQ-034 SHALL cover: req held high for 4 back-to-back reads with QDEPTH=2 and LATENCY=2 -> addr_ok drops after 2 accepts, data_ok arrives in order, and no request is lost or duplicated.
REQ-035 SHALL cover: half write to 0x31 (misaligned) with data 0xFFFF -> data_ok=1 and the word at 0x30 is unchanged.
REQ-036 SHALL cover: rst asserted one cycle after accepting a write of 0x5 to 0x40 -> no data_ok, addr_ok=1 the next cycle, and a later read of 0x40 returns its pre-write value.
REQ-037 SHALL cover: a write to 0x40 followed immediately by a read of addr 0x40 + 2^(MEM_AW+2) -> the read returns the written data, proving address wrap.
